// File: rtl/morse_key_controller.sv
`default_nettype none
// ============================================================================
// Module      : morse_key_controller
// Description : Front-end sequencer for a combinational Morse-to-ASCII
//               decoder. Synchronizes and debounces a straight key, times
//               marks and gaps, packs up to five dot/dash elements into the
//               10-bit decoder symbol vector, samples the decoder at letter
//               end and hands the character out through a one-entry
//               valid/ready buffer.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports:
//   clk         in   system clock
//   rst_n       in   asynchronous active-low reset
//   key_in      in   raw key (1 = pressed), asynchronous to clk
//   morse_vec   out  [9:0] symbol vector to decoder (first element in [9:8];
//                    10 = dot, 11 = dash, 01 = unused)
//   dec_ascii   in   [7:0] decoder ASCII result
//   dec_valid   in   decoder valid flag
//   char_out    out  [7:0] decoded character
//   char_valid  out  char_out holds an undelivered character
//   char_ready  in   consumer accepts char_out
//   err_invalid out  one-cycle pulse: invalid letter or more than 5 elements
//   err_overrun out  one-cycle pulse: character dropped, buffer full
//   busy        out  symbol in progress
// Optional feature macro:
//   WORD_SPACE_EN - emit one ASCII space after a word gap of 7 units
// ============================================================================
module morse_key_controller #(
  parameter int UNIT_CYCLES     = 5000000,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int MAX_ELEM        = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_in,
  output logic [9:0] morse_vec,
  input  logic [7:0] dec_ascii,
  input  logic       dec_valid,
  output logic [7:0] char_out,
  output logic       char_valid,
  input  logic       char_ready,
  output logic       err_invalid,
  output logic       err_overrun,
  output logic       busy
);

  localparam int         DUR_MAX = 7 * UNIT_CYCLES;
  localparam int         DUR_W   = $clog2(DUR_MAX + 1);
  localparam int         DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [9:0] VEC_PAD = 10'b0101010101;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MARK   = 2'd1,
    ST_GAP    = 2'd2,
    ST_DECODE = 2'd3
  } state_e;

  // --------------------------------------------------------------------------
  // Key conditioning
  // --------------------------------------------------------------------------
  logic            key_s1_q, key_s2_q;
  logic            key_db_q, key_db_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            w_rise, w_fall;

  always_comb begin
    key_db_d = key_db_q;
    db_cnt_d = '0;
    if (key_s2_q != key_db_q) begin
      if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        key_db_d = key_s2_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  // Edges are seen in the cycle the debouncer commits, so the FSM and the
  // duration counter react on the same clock edge that updates key_db.
  assign w_rise = key_db_d & ~key_db_q;
  assign w_fall = ~key_db_d & key_db_q;

  // --------------------------------------------------------------------------
  // Duration counter: saturating, cleared on every debounced edge
  // --------------------------------------------------------------------------
  logic [DUR_W-1:0] dur_q, dur_d;
  logic             w_is_dash;

  always_comb begin
    dur_d = dur_q;
    if (w_rise || w_fall) begin
      dur_d = '0;
    end else if (dur_q != DUR_W'(DUR_MAX)) begin
      dur_d = dur_q + 1'b1;
    end
  end

  // Mark length is dur_q + 1 in the cycle the release commits.
  assign w_is_dash = (dur_q >= DUR_W'(2 * UNIT_CYCLES - 1));

  // --------------------------------------------------------------------------
  // Symbol FSM
  // --------------------------------------------------------------------------
  state_e     state_q, state_d;
  logic [9:0] vec_q, vec_d;
  logic [2:0] idx_q, idx_d;
  logic       ovf_q, ovf_d;
  logic       w_dec_load;
  logic       w_inv;

  always_comb begin
    state_d    = state_q;
    vec_d      = vec_q;
    idx_d      = idx_q;
    ovf_d      = ovf_q;
    w_dec_load = 1'b0;
    w_inv      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (w_rise) state_d = ST_MARK;
      end
      ST_MARK: begin
        if (w_fall) begin
          if (idx_q < 3'(MAX_ELEM)) begin
            for (int e = 0; e < MAX_ELEM; e++) begin
              if (idx_q == 3'(e)) vec_d[9-2*e -: 2] = w_is_dash ? 2'b11 : 2'b10;
            end
            idx_d = idx_q + 3'd1;
          end else begin
            ovf_d = 1'b1;
          end
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        if (w_rise) begin
          state_d = ST_MARK;
        end else if (dur_q == DUR_W'(3 * UNIT_CYCLES - 1)) begin
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (dec_valid && !ovf_q) begin
          w_dec_load = 1'b1;
        end else begin
          w_inv = 1'b1;
        end
        vec_d   = VEC_PAD;
        idx_d   = 3'd0;
        ovf_d   = 1'b0;
        // key_db_d catches a press committing in this very cycle.
        state_d = key_db_d ? ST_MARK : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Word space generation
  // --------------------------------------------------------------------------
  logic w_space;

`ifdef WORD_SPACE_EN
  logic space_armed_q, space_armed_d;

  // Armed once a letter ends with the key up; the counter keeps running from
  // the last release, so reaching 7 units in IDLE means a word gap.
  always_comb begin
    space_armed_d = space_armed_q;
    w_space       = 1'b0;
    if (state_q == ST_DECODE) begin
      space_armed_d = ~key_db_d;
    end else if (state_q == ST_IDLE) begin
      if (w_rise) begin
        space_armed_d = 1'b0;
      end else if (space_armed_q && (dur_q == DUR_W'(DUR_MAX - 1))) begin
        w_space       = 1'b1;
        space_armed_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      space_armed_q <= 1'b0;
    end else begin
      space_armed_q <= space_armed_d;
    end
  end
`else
  assign w_space = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // One-entry output buffer
  // --------------------------------------------------------------------------
  logic [7:0] char_q, char_d;
  logic       cv_q, cv_d;
  logic       ovr_d;
  logic       w_buf_load;
  logic [7:0] w_buf_char;
  logic       w_drain;

  assign w_buf_load = w_dec_load | w_space;
  assign w_buf_char = w_space ? 8'h20 : dec_ascii;
  assign w_drain    = cv_q & char_ready;

  always_comb begin
    char_d = char_q;
    cv_d   = cv_q;
    ovr_d  = 1'b0;
    if (w_buf_load) begin
      // A drain in the same cycle frees the slot for the new character.
      if (!cv_q || w_drain) begin
        char_d = w_buf_char;
        cv_d   = 1'b1;
      end else begin
        ovr_d  = 1'b1;
      end
    end else if (w_drain) begin
      cv_d = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  logic err_inv_q, err_ovr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_s1_q  <= 1'b0;
      key_s2_q  <= 1'b0;
      key_db_q  <= 1'b0;
      db_cnt_q  <= '0;
      dur_q     <= '0;
      state_q   <= ST_IDLE;
      vec_q     <= VEC_PAD;
      idx_q     <= 3'd0;
      ovf_q     <= 1'b0;
      char_q    <= 8'h00;
      cv_q      <= 1'b0;
      err_inv_q <= 1'b0;
      err_ovr_q <= 1'b0;
    end else begin
      key_s1_q  <= key_in;
      key_s2_q  <= key_s1_q;
      key_db_q  <= key_db_d;
      db_cnt_q  <= db_cnt_d;
      dur_q     <= dur_d;
      state_q   <= state_d;
      vec_q     <= vec_d;
      idx_q     <= idx_d;
      ovf_q     <= ovf_d;
      char_q    <= char_d;
      cv_q      <= cv_d;
      err_inv_q <= w_inv;
      err_ovr_q <= ovr_d;
    end
  end

  assign morse_vec   = vec_q;
  assign char_out    = char_q;
  assign char_valid  = cv_q;
  assign err_invalid = err_inv_q;
  assign err_overrun = err_ovr_q;
  assign busy        = (state_q != ST_IDLE);

endmodule
`default_nettype wire
